// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Saturation constants are only consumed when PIPELINED_ADDER_SAT_EN is defined.
package pipelined_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned MAX_W = 256;

  function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Most positive signed value of the given width, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i + 1 < width; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative signed value of the given width, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
    logic [MAX_W-1:0] r;
    r = '0;
    r[width-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple slice built from chained full-adder cells.
module adder_slice #(
  parameter int unsigned SW = 8
) (
  input  logic [SW-1:0] a_s,
  input  logic [SW-1:0] b_s,
  input  logic          ci,
  output logic [SW-1:0] s_s,
  output logic          co
);

  logic [SW:0] c;

  always_comb begin
    c    = '0;
    s_s  = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SW; i++) begin
      s_s[i]  = a_s[i] ^ b_s[i] ^ c[i];
      c[i+1]  = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end
    co = c[SW];
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract: one SW-bit slice resolved per stage.
// Optional saturation (sat port + clamp) is enabled by PIPELINED_ADDER_SAT_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SW = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be in 1..WIDTH");
  end else if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             ovf;
    logic             a_msb;
    logic             b_msb;
`ifdef PIPELINED_ADDER_SAT_EN
    logic             sat;
`endif
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
  } stage_t;

  stage_t           stage_q [STAGES];
  stage_t           stage_d [STAGES];
  stage_t           head;
  logic [SW-1:0]    sl_a    [STAGES];
  logic [SW-1:0]    sl_b    [STAGES];
  logic [SW-1:0]    sl_s    [STAGES];
  logic             sl_ci   [STAGES];
  logic             sl_co   [STAGES];
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;

  assign op        = sub ? OP_SUB : OP_ADD;
  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].done;
  assign cout      = stage_q[STAGES-1].carry;
  assign overflow  = stage_q[STAGES-1].ovf;
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  always_comb begin
    b_eff      = (op == OP_SUB) ? ~b : b;
    c0         = (op == OP_SUB) ? 1'b1 : cin;
    head       = '0;
    head.valid = in_valid;
    head.carry = c0;
    head.a_msb = a[WIDTH-1];
    head.b_msb = b_eff[WIDTH-1];
`ifdef PIPELINED_ADDER_SAT_EN
    head.sat   = sat;
`endif
    head.op_a  = a;
    head.op_b  = b_eff;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign sl_a[k]  = a[SW-1:0];
      assign sl_b[k]  = b_eff[SW-1:0];
      assign sl_ci[k] = c0;
    end else begin : g_next
      assign sl_a[k]  = stage_q[k-1].op_a[k*SW +: SW];
      assign sl_b[k]  = stage_q[k-1].op_b[k*SW +: SW];
      assign sl_ci[k] = stage_q[k-1].carry;
    end

    adder_slice #(.SW(SW)) u_slice (
      .a_s (sl_a[k]),
      .b_s (sl_b[k]),
      .ci  (sl_ci[k]),
      .s_s (sl_s[k]),
      .co  (sl_co[k])
    );
  end

  // Each stage copies its predecessor and fills in its own slice; the last
  // stage also resolves overflow (and the clamp) so outputs come straight from flops.
  always_comb begin
    stage_t cur;
    cur     = '0;
    stage_d = stage_q;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) cur = head;
      else        cur = stage_q[k-1];
      cur.done[k*SW +: SW] = sl_s[k];
      cur.carry            = sl_co[k];
      if (k == STAGES - 1) begin
        cur.ovf = (cur.a_msb == cur.b_msb) && (cur.done[WIDTH-1] != cur.a_msb);
`ifdef PIPELINED_ADDER_SAT_EN
        if (cur.sat && cur.ovf) cur.done = cur.a_msb ? SAT_MIN : SAT_MAX;
`endif
      end
      if (!stall) stage_d[k] = cur;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: driver pushes model results, monitor pops on each output transfer.
module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             cin = 1'b0;
  logic             sat_r = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SAT_EN
    .sat       (sat_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          stamp;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   rnd_done;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference: signed/unsigned arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_, input logic tsub,
                                 input logic tcin, input logic tsat);
    exp_t e;
    longint sa, sb, r;
    longint unsigned ua, ub, us;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb_));
    ua = {32'b0, ta};
    ub = {32'b0, tb_};
    if (tsub) begin
      r  = sa - sb;
      us = ua - ub;
      e.cout = (ua >= ub);
    end else begin
      r  = sa + sb + longint'(tcin);
      us = ua + ub + {63'b0, tcin};
      e.cout = (us >= 64'h1_0000_0000);
    end
    e.sum = us[31:0];
    e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef PIPELINED_ADDER_SAT_EN
    if (tsat && e.ovf) e.sum = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    if (tsat) e.sum = e.sum;
`endif
    e.stamp = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tsub,
                      input logic tcin, input logic tsat, input bit lat);
    exp_t e;
    int   n;
    a = ta; b = tb_; sub = tsub; cin = tcin; sat_r = tsat; in_valid = 1'b1;
    e = model(ta, tb_, tsub, tcin, tsat);
    e.lat = lat;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.stamp = cyc;
        sbq.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        chk("send_timeout", {63'b0, in_ready}, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) chk(nm, {63'b0, out_valid}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("spurious_result", {63'b0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sum", {32'b0, sum}, {32'b0, e.sum});
        chk("cout", {63'b0, cout}, {63'b0, e.cout});
        chk("overflow", {63'b0, overflow}, {63'b0, e.ovf});
        if (e.lat) chk("latency", 64'(cyc - e.stamp), 64'(STAGES));
      end
    end
  end

  initial begin
    logic [31:0] held;
    int          seen;

    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_sum", {32'b0, sum}, 64'd0);
    chk("rst_cout", {63'b0, cout}, 64'd0);
    chk("rst_overflow", {63'b0, overflow}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Carry wraps out of the MSB
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Subtract with borrow, then signed overflow on subtract
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-to-back random stream, no backpressure
    for (int i = 0; i < 16; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    drain();

    // Result held at the output for five cycles
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_out_valid("bp_wait_valid");
    held = sum;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
      chk("bp_sum_stable", {32'b0, sum}, {32'b0, held});
      chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Random backpressure against a random stream
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with three operations in flight
    out_ready = 1'b0;
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0055, 32'h0000_0066, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_out_valid("mid_wait_valid");
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_sum", {32'b0, sum}, 64'd0);
    sbq.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_result", 64'(seen), 64'd0);
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;

`ifdef PIPELINED_ADDER_SAT_EN
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
`endif

    // Post-reset sanity that the pipe still computes
    send(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
